df_src_pipe: RTL and testbench
==============================

Name: df_src_pipe

Overview:
- Producer end of the ID-stage forwarding interface.
- Carries decoded destination info (waddr, wena, op, func) from ID through the EXE, MEM and WB pipeline registers.
- Publishes per-stage write-back address, enable and data that the ID hazard/forwarding unit samples.
- Consumes that unit's stall: inserts a bubble into EXE. Drives the register-file write port from WB.

Parameters:
- LW_OP, 6'b100011, opcode treated as a load; its MEM data comes from data memory.
- NOP_OP, 6'b000000, opcode placed in bubbles.
- CNT_W, 16, width of the statistics counters (see optional feature).

Ports:
- clk  in  1  pipeline clock; all registers update on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction this cycle.
- id_rf_waddr  in  5  destination register from decode.
- id_rf_wena  in  1  instruction writes the register file.
- id_op  in  6  opcode.
- id_func  in  6  function field.
- stall  in  1  hazard-unit stall (load-use); EXE receives a bubble.
- flush  in  1  branch/jump flush; EXE receives a bubble.
- exe_alu_result  in  32  combinational ALU result of the EXE instruction.
- mem_load_data  in  32  combinational data-memory read data for the MEM instruction.
- exe_rf_waddr  out  5  EXE destination.
- exe_rf_wena  out  1  EXE write enable.
- exe_op  out  6  EXE opcode.
- exe_func  out  6  EXE function field.
- exe_df_rf_wdata  out  32  EXE forward data.
- mem_rf_waddr  out  5  MEM destination.
- mem_rf_wena  out  1  MEM write enable.
- mem_df_rf_wdata  out  32  MEM forward data.
- wb_rf_waddr  out  5  register-file write address.
- wb_rf_wena  out  1  register-file write enable.
- wb_rf_wdata  out  32  register-file write data.
- bubble_cnt  out  CNT_W  bubbles inserted.
- load_cnt  out  CNT_W  loads retired.

Behaviour:
- Reset: all stage registers cleared. waddr 0, wena 0, op NOP_OP, func 0, data 0, counters 0, all outputs 0. Reset mid-stream discards all in-flight instructions. First write after reset release is no earlier than 3 cycles after the first id_valid.
- ID->EXE, each posedge:
  - stall or flush high, or id_valid low: load a bubble (wena 0, waddr 0, op NOP_OP, func 0).
  - otherwise: load the id_* fields.
  - wena is forced 0 when id_rf_waddr==0, so $0 is never forwarded or written.
- EXE->MEM always advances and is never held by stall.
  - Captures waddr, wena, op and exe_alu_result.
  - Sets internal mem_is_load = (exe_op==LW_OP) && exe_rf_wena.
- MEM->WB always advances.
  - Captures waddr, wena and mem_df_rf_wdata.
- exe_df_rf_wdata: combinational; exe_alu_result when exe_rf_wena, else 0. For a load in EXE the value is not meaningful. The consumer stalls on exe_op==LW_OP.
- mem_df_rf_wdata: combinational; mem_load_data if mem_is_load, else the registered ALU result; 0 when mem_rf_wena is 0.
- Latency: ID to WB write = 3 posedges. Forward data is visible at EXE after 1 posedge and at MEM after 2.
- Stall is single-cycle by contract. If stall stays high N cycles, N consecutive bubbles are inserted; no instruction is duplicated or dropped by this block.
- stall and flush together behave as one bubble; bubble_cnt increments by 1.
- A load stalled against: the cycle after stall, the load sits in MEM and mem_df_rf_wdata = mem_load_data. The consumer samples on negedge and must see the load value there.

Optional Feature:
- Macro DF_STAT_EN.
- Defined:
  - bubble_cnt increments on every posedge that inserts a bubble because of stall or flush (not for id_valid low).
  - load_cnt increments when a load retires with wb_rf_wena high.
  - Both saturate at all-ones and never wrap.
- Undefined: no counter registers; bubble_cnt and load_cnt are tied to 0.

Test Plan:
- Reset mid-flow: 3 instructions in flight, pulse rst between clock edges -> all outputs 0 immediately (asynchronous); no wb_rf_wena for the next 2 posedges.
- Straight ALU op: ID waddr=5, wena=1, op=0, exe_alu_result=0x1234 -> next cycle exe_rf_waddr=5, exe_df_rf_wdata=0x1234; following cycle mem_df_rf_wdata=0x1234; third cycle wb_rf_wdata=0x1234, wb_rf_wena=1.
- Load: op=LW_OP, waddr=8, mem_load_data=0xDEADBEEF -> in MEM, mem_df_rf_wdata=0xDEADBEEF (not the ALU address); in WB, wb_rf_wdata=0xDEADBEEF; load_cnt=1 with DF_STAT_EN.
- Stall: assert stall one cycle behind a load -> EXE shows wena=0, op=NOP_OP for one cycle while the load advances to MEM; bubble_cnt=1.
- $0 destination: id_rf_waddr=0, id_rf_wena=1 -> exe/mem/wb wena stay 0 for all stages.
- Saturation (DF_STAT_EN, CNT_W=4): 20 consecutive stall cycles -> bubble_cnt holds at 15. With the macro undefined -> bubble_cnt stays 0.

Source files
------------

// File: rtl/df_src_pipe.sv
// ============================================================================
// Module   : df_src_pipe
// Purpose  : Producer side of the ID-stage forwarding interface. Carries the
//            decoded destination fields through the EXE, MEM and WB pipeline
//            registers, publishes per-stage forward address/enable/data, and
//            drives the register-file write port from WB. A stall or flush
//            from the hazard unit turns the next EXE entry into a bubble.
// Options  : `define DF_STAT_EN adds saturating bubble/load statistics
//            counters; without it bubble_cnt and load_cnt are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module df_src_pipe #(
  parameter logic [5:0] LW_OP  = 6'b100011,
  parameter logic [5:0] NOP_OP = 6'b000000,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  // decode-stage fields
  input  logic             id_valid,
  input  logic [4:0]       id_rf_waddr,
  input  logic             id_rf_wena,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_func,
  // hazard-unit controls
  input  logic             stall,
  input  logic             flush,
  // combinational stage data
  input  logic [31:0]      exe_alu_result,
  input  logic [31:0]      mem_load_data,
  // EXE stage
  output logic [4:0]       exe_rf_waddr,
  output logic             exe_rf_wena,
  output logic [5:0]       exe_op,
  output logic [5:0]       exe_func,
  output logic [31:0]      exe_df_rf_wdata,
  // MEM stage
  output logic [4:0]       mem_rf_waddr,
  output logic             mem_rf_wena,
  output logic [31:0]      mem_df_rf_wdata,
  // WB stage / register-file write port
  output logic [4:0]       wb_rf_waddr,
  output logic             wb_rf_wena,
  output logic [31:0]      wb_rf_wdata,
  // statistics
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] load_cnt
);

  // A bubble is inserted for any hazard-unit request or an empty ID slot.
  logic hazard_bubble;
  logic id_bubble;
  logic id_wena_eff;

  // Registered ALU result and load marker for the MEM instruction.
  logic [31:0] mem_alu_result;
  logic        mem_is_load;

  assign hazard_bubble = stall | flush;
  assign id_bubble     = hazard_bubble | ~id_valid;
  // $0 is hard-wired zero: never write it and never forward it.
  assign id_wena_eff   = id_rf_wena & (id_rf_waddr != 5'd0);

  // ID -> EXE pipeline register: decoded fields or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_rf_waddr <= 5'd0;
      exe_rf_wena  <= 1'b0;
      exe_op       <= NOP_OP;
      exe_func     <= 6'd0;
    end else if (id_bubble) begin
      exe_rf_waddr <= 5'd0;
      exe_rf_wena  <= 1'b0;
      exe_op       <= NOP_OP;
      exe_func     <= 6'd0;
    end else begin
      exe_rf_waddr <= id_rf_waddr;
      exe_rf_wena  <= id_wena_eff;
      exe_op       <= id_op;
      exe_func     <= id_func;
    end
  end

  // EXE forward data; meaningless for a load, which the consumer stalls on.
  assign exe_df_rf_wdata = exe_rf_wena ? exe_alu_result : 32'd0;

  // EXE -> MEM pipeline register: always advances, never held by stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rf_waddr   <= 5'd0;
      mem_rf_wena    <= 1'b0;
      mem_alu_result <= 32'd0;
      mem_is_load    <= 1'b0;
    end else begin
      mem_rf_waddr   <= exe_rf_waddr;
      mem_rf_wena    <= exe_rf_wena;
      mem_alu_result <= exe_alu_result;
      mem_is_load    <= (exe_op == LW_OP) && exe_rf_wena;
    end
  end

  // MEM forward data: loads take memory read data, others the ALU result.
  always_comb begin
    mem_df_rf_wdata = 32'd0;
    if (mem_rf_wena) begin
      mem_df_rf_wdata = mem_is_load ? mem_load_data : mem_alu_result;
    end
  end

  // MEM -> WB pipeline register: drives the register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rf_waddr <= 5'd0;
      wb_rf_wena  <= 1'b0;
      wb_rf_wdata <= 32'd0;
    end else begin
      wb_rf_waddr <= mem_rf_waddr;
      wb_rf_wena  <= mem_rf_wena;
      wb_rf_wdata <= mem_df_rf_wdata;
    end
  end

`ifdef DF_STAT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] load_cnt_q;

  // Saturating count of bubbles requested by stall or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (hazard_bubble && (bubble_cnt_q != C_CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + C_CNT_ONE;
    end
  end

  // Saturating count of loads entering WB with a write enable; the count
  // becomes visible in the same cycle the load drives the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_q <= '0;
    end else if (mem_is_load && mem_rf_wena && (load_cnt_q != C_CNT_MAX)) begin
      load_cnt_q <= load_cnt_q + C_CNT_ONE;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign load_cnt   = load_cnt_q;
`else
  assign bubble_cnt = '0;
  assign load_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_df_src_pipe.sv
// ============================================================================
// Module   : tb_df_src_pipe
// Purpose  : Directed self-checking bench for df_src_pipe. Expected values
//            are hand-derived; counter expectations follow DF_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_df_src_pipe;

  localparam int CNT_W = 4;
  localparam logic [5:0] LW_OP = 6'b100011;
`ifdef DF_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rf_waddr;
  logic             id_rf_wena;
  logic [5:0]       id_op;
  logic [5:0]       id_func;
  logic             stall;
  logic             flush;
  logic [31:0]      exe_alu_result;
  logic [31:0]      mem_load_data;
  logic [4:0]       exe_rf_waddr;
  logic             exe_rf_wena;
  logic [5:0]       exe_op;
  logic [5:0]       exe_func;
  logic [31:0]      exe_df_rf_wdata;
  logic [4:0]       mem_rf_waddr;
  logic             mem_rf_wena;
  logic [31:0]      mem_df_rf_wdata;
  logic [4:0]       wb_rf_waddr;
  logic             wb_rf_wena;
  logic [31:0]      wb_rf_wdata;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] load_cnt;

  int n_checks;
  int n_fails;

  df_src_pipe #(
    .LW_OP (LW_OP),
    .NOP_OP(6'b000000),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rf_waddr    (id_rf_waddr),
    .id_rf_wena     (id_rf_wena),
    .id_op          (id_op),
    .id_func        (id_func),
    .stall          (stall),
    .flush          (flush),
    .exe_alu_result (exe_alu_result),
    .mem_load_data  (mem_load_data),
    .exe_rf_waddr   (exe_rf_waddr),
    .exe_rf_wena    (exe_rf_wena),
    .exe_op         (exe_op),
    .exe_func       (exe_func),
    .exe_df_rf_wdata(exe_df_rf_wdata),
    .mem_rf_waddr   (mem_rf_waddr),
    .mem_rf_wena    (mem_rf_wena),
    .mem_df_rf_wdata(mem_df_rf_wdata),
    .wb_rf_waddr    (wb_rf_waddr),
    .wb_rf_wena     (wb_rf_wena),
    .wb_rf_wdata    (wb_rf_wdata),
    .bubble_cnt     (bubble_cnt),
    .load_cnt       (load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] wa, input logic we, input logic [5:0] op,
                        input logic [5:0] fn);
    id_valid    = v;
    id_rf_waddr = wa;
    id_rf_wena  = we;
    id_op       = op;
    id_func     = fn;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    exe_alu_result = 32'd0;
    mem_load_data  = 32'd0;
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    tick();
    tick();
    // Reset state
    chk_eq("rst_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("rst_exe_op", {26'd0, exe_op}, 32'd0);
    chk_eq("rst_wb_wena", {31'd0, wb_rf_wena}, 32'd0);
    chk_eq("rst_wb_wdata", wb_rf_wdata, 32'd0);
    chk_eq("rst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Straight ALU op through EXE, MEM, WB
    id_set(1'b1, 5'd5, 1'b1, 6'd0, 6'h20);
    tick();
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    exe_alu_result = 32'h0000_1234;
    #1;
    chk_eq("alu_exe_waddr", {27'd0, exe_rf_waddr}, 32'd5);
    chk_eq("alu_exe_func", {26'd0, exe_func}, 32'h20);
    chk_eq("alu_exe_fwd", exe_df_rf_wdata, 32'h1234);
    tick();
    exe_alu_result = 32'h0000_FFFF;
    #1;
    chk_eq("alu_mem_waddr", {27'd0, mem_rf_waddr}, 32'd5);
    chk_eq("alu_mem_fwd", mem_df_rf_wdata, 32'h1234);
    chk_eq("alu_wb_idle", {31'd0, wb_rf_wena}, 32'd0);
    tick();
    chk_eq("alu_wb_wena", {31'd0, wb_rf_wena}, 32'd1);
    chk_eq("alu_wb_waddr", {27'd0, wb_rf_waddr}, 32'd5);
    chk_eq("alu_wb_wdata", wb_rf_wdata, 32'h1234);

    // Load followed by a dependent instruction that is stalled one cycle
    id_set(1'b1, 5'd8, 1'b1, LW_OP, 6'd0);
    tick();
    chk_eq("ld_exe_op", {26'd0, exe_op}, {26'd0, LW_OP});
    id_set(1'b1, 5'd9, 1'b1, 6'd0, 6'h21);
    stall = 1'b1;
    exe_alu_result = 32'h0000_0100;
    tick();
    mem_load_data = 32'hDEAD_BEEF;
    stall = 1'b0;
    #1;
    chk_eq("stall_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("stall_exe_op", {26'd0, exe_op}, 32'd0);
    chk_eq("ld_mem_waddr", {27'd0, mem_rf_waddr}, 32'd8);
    chk_eq("ld_mem_fwd", mem_df_rf_wdata, 32'hDEAD_BEEF);
    chk_eq("stall_bubble_cnt", {28'd0, bubble_cnt}, STAT ? 32'd1 : 32'd0);
    tick();
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    exe_alu_result = 32'h0000_0055;
    mem_load_data  = 32'h0BAD_0BAD;
    #1;
    chk_eq("dep_exe_waddr", {27'd0, exe_rf_waddr}, 32'd9);
    chk_eq("bub_mem_fwd", mem_df_rf_wdata, 32'd0);
    chk_eq("ld_wb_waddr", {27'd0, wb_rf_waddr}, 32'd8);
    chk_eq("ld_wb_wdata", wb_rf_wdata, 32'hDEAD_BEEF);
    chk_eq("ld_load_cnt", {28'd0, load_cnt}, STAT ? 32'd1 : 32'd0);
    tick();
    chk_eq("dep_mem_fwd", mem_df_rf_wdata, 32'h55);
    tick();
    chk_eq("dep_wb_wdata", wb_rf_wdata, 32'h55);
    chk_eq("dep_wb_waddr", {27'd0, wb_rf_waddr}, 32'd9);

    // $0 destination never enables a write
    id_set(1'b1, 5'd0, 1'b1, 6'd0, 6'd0);
    exe_alu_result = 32'h0000_0077;
    tick();
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    chk_eq("z0_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("z0_exe_fwd", exe_df_rf_wdata, 32'd0);
    tick();
    chk_eq("z0_mem_wena", {31'd0, mem_rf_wena}, 32'd0);
    tick();
    chk_eq("z0_wb_wena", {31'd0, wb_rf_wena}, 32'd0);

    // stall+flush together count once; flush alone counts once
    id_set(1'b1, 5'd3, 1'b1, 6'd0, 6'd0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk_eq("sf_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("sf_bubble_cnt", {28'd0, bubble_cnt}, STAT ? 32'd2 : 32'd0);
    stall = 1'b0;
    tick();
    chk_eq("fl_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("fl_bubble_cnt", {28'd0, bubble_cnt}, STAT ? 32'd3 : 32'd0);
    flush = 1'b0;
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    tick();
    chk_eq("inv_bubble_cnt", {28'd0, bubble_cnt}, STAT ? 32'd3 : 32'd0);

    // 20 stall cycles saturate the 4-bit counter
    id_set(1'b1, 5'd4, 1'b1, 6'd0, 6'd0);
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    stall = 1'b0;
    chk_eq("sat_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("sat_bubble_cnt", {28'd0, bubble_cnt}, STAT ? 32'd15 : 32'd0);
    tick();
    chk_eq("post_sat_exe_waddr", {27'd0, exe_rf_waddr}, 32'd4);

    // Three instructions in flight, then an asynchronous reset pulse
    exe_alu_result = 32'h0000_0077;
    id_set(1'b1, 5'd1, 1'b1, 6'd0, 6'd0);
    tick();
    id_set(1'b1, 5'd2, 1'b1, 6'd0, 6'd0);
    tick();
    id_set(1'b0, 5'd0, 1'b0, 6'd0, 6'd0);
    chk_eq("flow_wb_wena", {31'd0, wb_rf_wena}, 32'd1);
    chk_eq("flow_mem_wena", {31'd0, mem_rf_wena}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_exe_wena", {31'd0, exe_rf_wena}, 32'd0);
    chk_eq("arst_mem_wena", {31'd0, mem_rf_wena}, 32'd0);
    chk_eq("arst_wb_wena", {31'd0, wb_rf_wena}, 32'd0);
    chk_eq("arst_wb_wdata", wb_rf_wdata, 32'd0);
    chk_eq("arst_mem_fwd", mem_df_rf_wdata, 32'd0);
    chk_eq("arst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
    chk_eq("arst_load_cnt", {28'd0, load_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk_eq("arst_wb_idle1", {31'd0, wb_rf_wena}, 32'd0);
    tick();
    chk_eq("arst_wb_idle2", {31'd0, wb_rf_wena}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
